// File: rtl/blink_pkg.sv
// blink_pkg: shared state encoding and default timing for key_pulse_blinker.
//   blink_state_t  : IDLE (Out low), ON (Out high), GAP (enforced low time)
//   ON_CYCLES_DEF  : default on-time, 100 ms at 50 MHz
//   GAP_CYCLES_DEF : default off-gap, 100 ms at 50 MHz
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } blink_state_t;

    localparam int ON_CYCLES_DEF  = 5_000_000;
    localparam int GAP_CYCLES_DEF = 5_000_000;

endpackage

// File: rtl/key_pulse_blinker.sv
// key_pulse_blinker: turns single-cycle event strobes into countable, human-visible LED blinks.
//   Clk      in   system clock
//   Reset    in   synchronous active-high reset; discards queued events and clears Overflow
//   In       in   event strobe; each cycle sampled high is one event
//   Out      out  registered blink output, high ON_CYCLES cycles per event
//   Busy     out  high while a blink or its trailing gap is in progress
//   Pending  out  events queued behind the current blink (saturating)
//   Overflow out  sticky flag, set when an event is dropped because Pending is full
module key_pulse_blinker
    import blink_pkg::*;
#(
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int PEND_W     = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In,
    output logic              Out,
    output logic              Busy,
    output logic [PEND_W-1:0] Pending,
    output logic              Overflow
);

    localparam int CNT_MAX = ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES;
    localparam int CW      = CNT_MAX > 1 ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0]     ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    blink_state_t      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              out_q, busy_q, ovf_q, ovf_d;
    logic              start, deq, inc, sat;

    always_comb begin
        start   = state_q == IDLE && (In || pend_q != '0);
        // A start with a non-empty queue serves the oldest queued event, so a
        // simultaneous In must still be queued; with an empty queue In itself is served.
        deq     = start && pend_q != '0;
        inc     = In && !(start && pend_q == '0);
        sat     = inc && !deq && pend_q == PEND_MAX;
        pend_d  = (inc == deq || sat) ? pend_q : inc ? pend_q + PEND_W'(1) : pend_q - PEND_W'(1);
        ovf_d   = ovf_q | sat;
        state_d = IDLE;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                state_d = start ? ON : IDLE;
                cnt_d   = start ? ON_LOAD : '0;
            end
            ON: begin
                state_d = cnt_q == '0 ? GAP : ON;
                cnt_d   = cnt_q == '0 ? GAP_LOAD : cnt_q - CW'(1);
            end
            GAP: begin
                state_d = cnt_q == '0 ? IDLE : GAP;
                cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= state_d == ON;
            busy_q  <= state_d != IDLE;
        end
    end

    assign Out      = out_q;
    assign Busy     = busy_q;
    assign Pending  = pend_q;
    assign Overflow = ovf_q;

endmodule
